aer_spike_encoder: RTL and testbench
====================================

// Module: aer_spike_encoder
// PURPOSE
//  Transmit side of the AER link. Takes per-channel spike pulses from the neuron array
//  and timestamps them with a free-running counter. Arbitrates pending events round-robin,
//  packs each into a 24-bit word {channel_id[3:0], timestamp[19:0]}, buffers it and
//  streams it out over a valid/ready handshake toward the AER input pipeline.
// PARAMETERS
//  NUM_CH      16  spike input channels; fixed = 2**CH_W
//  CH_W        4   channel id width, word bits [23:20]
//  TS_W        20  timestamp width, word bits [19:0]
//  TICK_DIV    1   clk cycles per timestamp increment (>=1)
//  FIFO_DEPTH  8   output buffer depth in words (power of 2)
// PORTS
//  clk            in   1       single clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  spike_in       in   NUM_CH  bit i high = spike on channel i this cycle (sampled per cycle)
//  aer_out        out  24      {channel_id, timestamp}; valid when aer_out_valid
//  aer_out_valid  out  1       FIFO not empty
//  aer_out_ready  in   1       sink accepts; transfer = aer_out_valid & aer_out_ready
//  fifo_full      out  1       output buffer holds FIFO_DEPTH words
//  fifo_empty     out  1       output buffer holds 0 words
//  overflow       out  1       sticky: at least one spike dropped since reset
//  drop_count     out  8       dropped-spike count, saturates at 255
//  timestamp_now  out  TS_W    current timestamp counter value
// BEHAVIOUR
//  Reset (rst=1 at edge): ts counter, prescaler, pend[], last_grant=NUM_CH-1, FIFO pointers,
//   overflow, drop_count all 0. Outputs next cycle: aer_out_valid=0, fifo_empty=1,
//   fifo_full=0, aer_out=0. Mid-operation reset discards all pending and buffered events.
//  Timestamp: prescaler counts 0..TICK_DIV-1; ts increments when the prescaler wraps.
//   Wraps 2**TS_W-1 -> 0 silently; no wrap event is emitted.
//  Capture, stage 1: spike_in[i]=1 at edge N sets pend[i] and loads pend_ts[i] with the
//   ts value present in cycle N.
//   - If pend[i] is already set and not granted this cycle, the spike is dropped: pend_ts
//     is unchanged, overflow=1, drop_count+1 (saturating).
//   - Multiple channels may spike in the same cycle. Each one is captured independently.
//  Arbitrate/write, stage 2: each edge, if any pend is set and !fifo_full (evaluated at
//   cycle start), grant = first set pend at index last_grant+1, +2, ... (mod NUM_CH).
//   - The granted word is written to the FIFO, pend[grant] is cleared, and last_grant=grant.
//   - Exactly one write per cycle at most.
//   - If spike_in[grant] is high the same cycle, the new spike re-sets pend[grant] with the
//     new ts. It is not a drop.
//  FIFO is full at cycle start: no grant; pend[] holds. A read in the same cycle does not
//   enable a write until the next cycle.
//  Output: first-word-fall-through. aer_out = head word whenever aer_out_valid=1. It is held
//   stable while valid & !ready. Simultaneous read and write when not full: count unchanged.
//  Latency: spike at edge N, empty FIFO, idle arbiter -> aer_out_valid=1 after edge N+1.
//   Throughput is 1 word/cycle.
//  Width rule: channel_id = grant[CH_W-1:0]; word = {channel_id, pend_ts[grant]}.
// TESTING
//  1 Reset, then spike_in=16'h0004 while timestamp_now=0x00010 -> after 2 edges aer_out=24'h200010,
//    valid=1. ready=1 -> fifo_empty=1 next cycle.
//  2 spike_in=16'hFFFF for one cycle, ready=1 -> 16 words, ids 0,1,...,F on consecutive cycles,
//    all with the same timestamp, drop_count=0.
//  3 ready=0, 12 single-channel spikes on distinct channels -> fifo_full after 8 writes,
//    4 events held pending. Raise ready -> all 12 delivered in round-robin order, none lost.
//  4 Channel 3 spikes twice while blocked (FIFO full) -> overflow=1, drop_count=1,
//    delivered word carries the first timestamp.
//  5 Preload ts near 0xFFFFE, spike each cycle on ch 1 -> timestamps 0xFFFFE, 0xFFFFF,
//    0x00000 delivered in order.
//  6 Assert rst with 5 words buffered and 3 pending -> next cycle valid=0, empty=1,
//    drop_count=0; no stale word later.

Source files
------------

// File: rtl/aer_spike_encoder_if.sv
// AER output stream: one word per transfer, valid/ready handshake.
// The encoder drives the word and valid; the downstream pipeline drives ready.
interface aer_spike_encoder_if #(
  parameter int WORD_W = 24
) ();
  logic [WORD_W-1:0] aer_out;
  logic              aer_out_valid;
  logic              aer_out_ready;

  modport master (
    output aer_out,
    output aer_out_valid,
    input  aer_out_ready
  );

  modport slave (
    input  aer_out,
    input  aer_out_valid,
    output aer_out_ready
  );
endinterface

// File: rtl/aer_spike_encoder.sv
// AER transmit encoder: timestamps per-channel spikes, arbitrates pending events round-robin
// and streams {channel_id, timestamp} words out of a first-word-fall-through buffer.
module aer_spike_encoder #(
  parameter int              NUM_CH     = 16,
  parameter int              CH_W       = 4,
  parameter int              TS_W       = 20,
  parameter int              TICK_DIV   = 1,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [TS_W-1:0] TS_RESET   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          spike_in,
  aer_spike_encoder_if.master        aer,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  output logic [TS_W-1:0]            timestamp_now
);

  localparam int WORD_W = CH_W + TS_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW     = $clog2(NUM_CH + 1);

  logic [PS_W-1:0]   ps_q;
  logic [TS_W-1:0]   ts_q;
  logic              tick;

  logic [NUM_CH-1:0] pend_q;
  logic [TS_W-1:0]   pend_ts_q [NUM_CH];
  logic [CH_W-1:0]   last_grant_q;

  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] gnt_vec;
  logic [NUM_CH-1:0] hold_vec;
  logic [NUM_CH-1:0] drop_vec;
  logic [NUM_CH-1:0] load_vec;
  logic [NUM_CH-1:0] pend_d;

  logic [DW-1:0]     n_drop;
  logic [8:0]        drop_sum;
  logic [7:0]        drop_next;
  logic              overflow_q;
  logic [7:0]        drop_count_q;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic [WORD_W-1:0] wr_word;

  // Timestamp prescaler: ts advances on the cycle the prescaler wraps.
  assign tick = (ps_q == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
      ts_q <= TS_RESET;
    end else if (tick) begin
      ps_q <= '0;
      ts_q <= ts_q + 1'b1;
    end else begin
      ps_q <= ps_q + 1'b1;
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!full) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (!grant_vld && pend_q[last_grant_q + CH_W'(k)]) begin
          grant_vld = 1'b1;
          grant_idx = last_grant_q + CH_W'(k);
        end
      end
    end
  end

  assign gnt_vec  = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;
  assign hold_vec = pend_q & ~gnt_vec;
  assign drop_vec = spike_in & hold_vec;
  assign load_vec = spike_in & ~hold_vec;
  assign pend_d   = spike_in | hold_vec;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_drop = n_drop + DW'(drop_vec[i]);
    end
  end

  assign drop_sum  = {1'b0, drop_count_q} + 9'(n_drop);
  assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // A channel granted this cycle may be reloaded by a same-cycle spike without a drop.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_vec[i]) pend_ts_q[i] <= ts_q;
    end
  end

  assign wr_en   = grant_vld;
  assign rd_en   = !empty && aer.aer_out_ready;
  assign wr_word = {grant_idx, pend_ts_q[grant_idx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      pend_q       <= pend_d;
      drop_count_q <= drop_next;
      if (grant_vld) last_grant_q <= grant_idx;
      if (|drop_vec) overflow_q   <= 1'b1;
      if (wr_en)     wr_ptr_q     <= wr_ptr_q + 1'b1;
      if (rd_en)     rd_ptr_q     <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Word is forced to zero while empty so no stale data shows after reset.
  assign aer.aer_out       = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign aer.aer_out_valid = !empty;

  assign fifo_full     = full;
  assign fifo_empty    = empty;
  assign overflow      = overflow_q;
  assign drop_count    = drop_count_q;
  assign timestamp_now = ts_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Randomized and directed bench for aer_spike_encoder with an event-level reference model
// feeding a scoreboard queue that a separate monitor drains on each output transfer.
module tb_aer_spike_encoder;

  localparam int NCH   = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] spike;
  logic        fifo_full, fifo_empty, overflow;
  logic [7:0]  drop_count;
  logic [19:0] ts_now;

  logic        wrap_rst;
  logic [15:0] wrap_spike;
  logic        wrap_full, wrap_empty, wrap_ovf;
  logic [7:0]  wrap_drop;
  logic [19:0] wrap_ts;

  aer_spike_encoder_if #(.WORD_W(24)) aer_if ();
  aer_spike_encoder_if #(.WORD_W(24)) wrap_if ();

  aer_spike_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .spike_in      (spike),
    .aer           (aer_if),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .timestamp_now (ts_now)
  );

  // Second instance starts its timestamp just below the wrap point.
  aer_spike_encoder #(.TS_RESET(20'hFFFF8)) dut_wrap (
    .clk           (clk),
    .rst           (wrap_rst),
    .spike_in      (wrap_spike),
    .aer           (wrap_if),
    .fifo_full     (wrap_full),
    .fifo_empty    (wrap_empty),
    .overflow      (wrap_ovf),
    .drop_count    (wrap_drop),
    .timestamp_now (wrap_ts)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_w[$];

  bit          m_pend [NCH];
  logic [19:0] m_pts  [NCH];
  int          m_last;
  int          m_occ;
  int          m_drop;
  bit          m_ovf;
  logic [19:0] m_ts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Event-level model of one clock cycle, given the inputs present during that cycle.
  task automatic model_step(input logic [15:0] sp, input logic rdy, input logic r);
    int g;
    bit rd;
    if (r) begin
      for (int i = 0; i < NCH; i++) m_pend[i] = 1'b0;
      m_last = NCH - 1;
      m_occ  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
      m_ts   = '0;
      exp_q.delete();
      return;
    end
    rd = rdy && (m_occ > 0);
    g  = -1;
    if (m_occ < DEPTH) begin
      for (int k = 1; k <= NCH; k++) begin
        if (g < 0 && m_pend[(m_last + k) % NCH]) g = (m_last + k) % NCH;
      end
    end
    if (g >= 0) begin
      exp_q.push_back({4'(g), m_pts[g]});
      m_pend[g] = 1'b0;
      m_last    = g;
      m_occ++;
    end
    if (rd) m_occ--;
    for (int i = 0; i < NCH; i++) begin
      if (sp[i]) begin
        if (m_pend[i]) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end else begin
          m_pend[i] = 1'b1;
          m_pts[i]  = m_ts;
        end
      end
    end
    m_ts = m_ts + 20'd1;
  endtask

  task automatic step(input logic [15:0] sp, input logic rdy, input logic r);
    spike = sp;
    aer_if.aer_out_ready = rdy;
    rst = r;
    model_step(sp, rdy, r);
    @(posedge clk);
    #1;
    chk("valid",      32'(aer_if.aer_out_valid), 32'(m_occ > 0));
    chk("fifo_empty", 32'(fifo_empty),           32'(m_occ == 0));
    chk("fifo_full",  32'(fifo_full),            32'(m_occ == DEPTH));
    chk("overflow",   32'(overflow),             32'(m_ovf));
    chk("drop_count", 32'(drop_count),           32'(m_drop));
    chk("timestamp",  32'(ts_now),               32'(m_ts));
  endtask

  // Scoreboard monitor: head word must match whenever valid; pop on transfer.
  initial forever begin
    @(negedge clk);
    if (!rst && aer_if.aer_out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %h expected no word (t=%0t)", aer_if.aer_out, $time);
      end else begin
        chk("aer_head", 32'(aer_if.aer_out), 32'(exp_q[0]));
        if (aer_if.aer_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!wrap_rst && wrap_if.aer_out_valid && wrap_if.aer_out_ready) begin
      if (exp_w.size() == 0) begin
        n_total++;
        $display("FAIL wrap_unexpected: got %h expected no word (t=%0t)", wrap_if.aer_out, $time);
      end else begin
        chk("wrap_word", 32'(wrap_if.aer_out), 32'(exp_w.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] order [12];
    order = '{4'd5, 4'd0, 4'd9, 4'd12, 4'd3, 4'd14, 4'd7, 4'd1, 4'd10, 4'd6, 4'd15, 4'd2};

    spike = '0;
    rst = 1'b1;
    aer_if.aer_out_ready = 1'b0;
    wrap_rst = 1'b1;
    wrap_spike = '0;
    wrap_if.aer_out_ready = 1'b0;

    step(16'h0, 1'b0, 1'b1);
    step(16'h0, 1'b0, 1'b1);
    chk("rst_aer_out", 32'(aer_if.aer_out), 32'h0);

    // Single spike on channel 2 at ts 0x10
    for (int i = 0; i < 64 && ts_now != 20'h10; i++) step(16'h0, 1'b0, 1'b0);
    chk("ts_reach_10", 32'(ts_now), 32'h10);
    step(16'h0004, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    chk("t1_word", 32'(aer_if.aer_out), 32'h200010);
    chk("t1_valid", 32'(aer_if.aer_out_valid), 32'h1);
    step(16'h0000, 1'b1, 1'b0);
    chk("t1_empty", 32'(fifo_empty), 32'h1);

    // All channels at once from a fresh arbiter
    step(16'h0, 1'b0, 1'b1);
    step(16'hFFFF, 1'b1, 1'b0);
    repeat (20) step(16'h0, 1'b1, 1'b0);
    chk("t2_drop", 32'(drop_count), 32'h0);
    chk("t2_drained", 32'(exp_q.size()), 32'h0);

    // Backpressure: 12 distinct channels, 8 buffered and 4 pending
    for (int i = 0; i < 12; i++) step(16'(1) << order[i], 1'b0, 1'b0);
    repeat (4) step(16'h0, 1'b0, 1'b0);
    chk("t3_full", 32'(fifo_full), 32'h1);
    repeat (20) step(16'h0, 1'b1, 1'b0);
    chk("t3_drained", 32'(exp_q.size()), 32'h0);

    // Channel 3 spikes twice while the buffer is full
    step(16'h01F7, 1'b0, 1'b0);
    repeat (8) step(16'h0, 1'b0, 1'b0);
    chk("t4_full", 32'(fifo_full), 32'h1);
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b0);
    chk("t4_overflow", 32'(overflow), 32'h1);
    chk("t4_drop", 32'(drop_count), 32'h1);
    repeat (20) step(16'h0, 1'b1, 1'b0);
    chk("t4_drained", 32'(exp_q.size()), 32'h0);

    // Drop counter saturation
    repeat (25) step(16'hFFFF, 1'b0, 1'b0);
    chk("sat_drop", 32'(drop_count), 32'hFF);
    repeat (40) step(16'h0, 1'b1, 1'b0);
    chk("sat_drained", 32'(exp_q.size()), 32'h0);

    // Reset with 5 words buffered and 3 pending
    step(16'h001F, 1'b0, 1'b0);
    repeat (5) step(16'h0, 1'b0, 1'b0);
    step(16'h0700, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    chk("t6_valid", 32'(aer_if.aer_out_valid), 32'h0);
    chk("t6_empty", 32'(fifo_empty), 32'h1);
    chk("t6_drop", 32'(drop_count), 32'h0);
    repeat (10) step(16'h0, 1'b1, 1'b0);
    step(16'h0010, 1'b1, 1'b0);
    repeat (4) step(16'h0, 1'b1, 1'b0);
    chk("t6_drained", 32'(exp_q.size()), 32'h0);

    // Random traffic with random backpressure
    repeat (400) step(16'($urandom & $urandom & $urandom), ($urandom_range(0, 3) != 0), 1'b0);
    repeat (60) step(16'h0, 1'b1, 1'b0);
    chk("rand_drained", 32'(exp_q.size()), 32'h0);

    // Timestamp wrap on the second instance
    spike = '0;
    @(posedge clk);
    #1;
    wrap_rst = 1'b0;
    for (int i = 0; i < 32 && wrap_ts != 20'hFFFFE; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wrap_ts_reach", 32'(wrap_ts), 32'hFFFFE);
    exp_w.push_back(24'h1FFFFE);
    exp_w.push_back(24'h1FFFFF);
    exp_w.push_back(24'h100000);
    wrap_if.aer_out_ready = 1'b1;
    wrap_spike = 16'h0002;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    wrap_spike = '0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("wrap_drained", 32'(exp_w.size()), 32'h0);
    chk("wrap_drop", 32'(wrap_drop), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
